// File: rtl/io_input_conditioner.sv
// io_input_conditioner
// Conditions the board push-buttons and slide-switches for the core:
// two-flop synchronization, key polarity normalization (1 = pressed) and an
// independent per-bit debouncer. Only the debounced stable registers drive
// io_input_bus. input_changed is a registered pulse for any stable-bit update.
module io_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  raw_key,
  input  logic [9:0]  raw_sw,
  output logic [13:0] io_input_bus,
  output logic        input_changed
);

  localparam int NB    = 14;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

  // Counter value on the final mismatch edge that accepts the new level.
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Key bits are inverted after synchronization when the pins read 0 = pressed.
  localparam logic [3:0]    KEY_INV   = KEY_ACTIVE_LOW ? 4'hF : 4'h0;

  // Synchronizers reset to the released pin level so that leaving reset never
  // looks like a press: keys idle high when active-low, switches idle low.
  localparam logic [NB-1:0] SYNC_IDLE = {KEY_INV, 10'b0};

  // Saturating increment; the accept logic normally clears before the top.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [NB-1:0]    raw_bus;
  logic [NB-1:0]    sync_p0;
  logic [NB-1:0]    sync_p1;
  logic [NB-1:0]    cond_p1;
  logic [NB-1:0]    stable;
  logic [NB-1:0]    differ;
  logic [NB-1:0]    load;
  logic [CNT_W-1:0] cnt [NB];

  assign raw_bus = {raw_key, raw_sw};

  // Two-flop synchronizer on every raw pin (stage p0 is the metastability catcher).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_p0 <= SYNC_IDLE;
      sync_p1 <= SYNC_IDLE;
    end else begin
      sync_p0 <= raw_bus;
      sync_p1 <= sync_p0;
    end
  end

  // Polarity normalization and per-bit mismatch / accept decision.
  always_comb begin
    cond_p1 = {sync_p1[13:10] ^ KEY_INV, sync_p1[9:0]};
    differ  = cond_p1 ^ stable;
    load    = '0;
    for (int b = 0; b < NB; b++) begin
      load[b] = differ[b] && (cnt[b] == TERM);
    end
  end

  // Per-bit debounce counters: cleared on match or on accept, counting otherwise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < NB; b++) begin
        cnt[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (!differ[b] || load[b]) begin
          cnt[b] <= '0;
        end else begin
          cnt[b] <= sat_inc(cnt[b]);
        end
      end
    end
  end

  // Stable registers take the synchronized level on accept; one pulse per update edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stable        <= '0;
      input_changed <= 1'b0;
    end else begin
      stable        <= stable ^ load;
      input_changed <= |load;
    end
  end

  assign io_input_bus = stable;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Bench for io_input_conditioner with DEBOUNCE_CYCLES=4 (scoreboarded) plus a
// DEBOUNCE_CYCLES=1 instance sharing the same pins for minimum-latency checks.
// The reference model accepts a bit when the last DEBOUNCE_CYCLES synchronized
// samples all disagree with the model's stable value.
module tb_io_input_conditioner;

  localparam int D = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  raw_key = 4'hF;
  logic [9:0]  raw_sw = 10'h000;
  logic [13:0] bus4;
  logic        chg4;
  logic [13:0] bus1;
  logic        chg1;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;

  io_input_conditioner #(.DEBOUNCE_CYCLES(D), .KEY_ACTIVE_LOW(1'b1)) u_dut (
    .clock(clock), .reset(reset), .raw_key(raw_key), .raw_sw(raw_sw),
    .io_input_bus(bus4), .input_changed(chg4)
  );

  io_input_conditioner #(.DEBOUNCE_CYCLES(1), .KEY_ACTIVE_LOW(1'b1)) u_dut1 (
    .clock(clock), .reset(reset), .raw_key(raw_key), .raw_sw(raw_sw),
    .io_input_bus(bus1), .input_changed(chg1)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: history window of conditioned raw samples, pushes expectations.
  logic [14:0] exp_q[$];
  logic [13:0] hist [D+1];
  logic [13:0] m_stable;
  logic        m_changed;
  logic [13:0] flips;

  always @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k <= D; k++) hist[k] = 14'h0;
      m_stable  = 14'h0;
      m_changed = 1'b0;
    end else begin
      flips = 14'h3FFF;
      for (int k = 1; k <= D; k++) flips = flips & (hist[k] ^ m_stable);
      m_stable  = m_stable ^ flips;
      m_changed = |flips;
      for (int k = D; k >= 1; k--) hist[k] = hist[k-1];
      hist[0] = {~raw_key, raw_sw};
    end
    exp_q.push_back({m_stable, m_changed});
  end

  // Scoreboard checker: pop one expectation per edge, compare just after the edge.
  always @(posedge clock) begin
    logic [14:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_bus", 32'(bus4), 32'(e[14:1]));
      chk("sb_changed", 32'(chg4), 32'(e[0]));
      if (chg4) pulses++;
    end
  end

  // Edges from now until each instance shows the expected bus (-1 if never).
  task automatic measure(input logic [13:0] exp, output int n4, output int n1);
    n4 = -1;
    n1 = -1;
    for (int i = 1; i <= 40 && (n4 < 0 || n1 < 0); i++) begin
      @(posedge clock);
      #2;
      if (n4 < 0 && bus4 == exp) n4 = i;
      if (n1 < 0 && bus1 == exp) n1 = i;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  initial begin
    int n4, n1, p0;

    // Reset with keys released and switches low; nothing may appear afterwards.
    repeat (3) @(negedge clock);
    chk("rst_bus", 32'(bus4), 32'h0);
    chk("rst_changed", 32'(chg4), 32'h0);
    @(negedge clock) reset = 1'b1;
    repeat (12) @(negedge clock);
    chk("idle_bus", 32'(bus4), 32'h0);

    // Single switch rise: 6 edges at DEBOUNCE_CYCLES=4, 3 edges at 1.
    raw_sw = 10'h008;
    measure(14'h0008, n4, n1);
    chk("lat_sw3", 32'(n4), 32'd6);
    chk("lat1_sw3", 32'(n1), 32'd3);
    repeat (4) @(negedge clock);

    // Three-cycle key glitch is rejected.
    p0 = pulses;
    raw_key = 4'hE;
    repeat (3) @(negedge clock);
    raw_key = 4'hF;
    repeat (12) @(negedge clock);
    chk("glitch_bus", 32'(bus4), 32'h0008);
    chk("glitch_pulses", 32'(pulses - p0), 32'd0);

    // Many bits on one edge: same-edge update, single pulse.
    p0 = pulses;
    raw_key = 4'h6;
    raw_sw  = 10'h201;
    measure(14'h2601, n4, n1);
    chk("lat_multi", 32'(n4), 32'd6);
    chk("lat1_multi", 32'(n1), 32'd3);
    repeat (4) @(negedge clock);
    chk("multi_pulses", 32'(pulses - p0), 32'd1);

    // High 3, low 1, high again: counting restarts from the final rise.
    raw_sw = 10'h200;
    repeat (10) @(negedge clock);
    chk("drop_sw0", 32'(bus4), 32'h2600);
    raw_sw = 10'h201;
    repeat (3) @(negedge clock);
    raw_sw = 10'h200;
    @(negedge clock);
    raw_sw = 10'h201;
    measure(14'h2601, n4, n1);
    chk("lat_restart", 32'(n4), 32'd6);
    repeat (4) @(negedge clock);

    // Reset mid-count clears immediately and discards the partial count.
    raw_sw = 10'h001;
    repeat (10) @(negedge clock);
    chk("pre_rst_bus", 32'(bus4), 32'h2401);
    raw_sw = 10'h201;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("async_rst_bus", 32'(bus4), 32'h0);
    chk("async_rst_changed", 32'(chg4), 32'h0);
    @(negedge clock) reset = 1'b1;
    measure(14'h2601, n4, n1);
    chk("lat_after_rst", 32'(n4), 32'd6);
    chk("lat1_after_rst", 32'(n1), 32'd3);
    repeat (4) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/io_input_conditioner.md
IO_INPUT_CONDITIONER -- requirements
Module: io_input_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive clock cycles an input must hold a new level before it is accepted; legal range 1..2^20.
REQ-002 The block SHALL have parameter KEY_ACTIVE_LOW, default 1, meaning raw keys read 0 when pressed.
REQ-003 The block SHALL have port clock, input, 1 bit, the single system clock (same clock as the core).
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset (0 = reset asserted).
REQ-005 The block SHALL have port raw_key, input, 4 bits, asynchronous push-button pins.
REQ-006 The block SHALL have port raw_sw, input, 10 bits, asynchronous slide-switch pins.
REQ-007 The block SHALL have port io_input_bus, output, 14 bits, conditioned inputs: [13:10] = KEY (1 = pressed), [9:0] = SW; feeds the core's io_input_bus directly.
REQ-008 The block SHALL have port input_changed, output, 1 bit, one-cycle pulse when any bit of io_input_bus changes.

Function
REQ-009 Each of the 14 inputs SHALL pass through a two-flop synchronizer before any other logic.
REQ-010 Raw key bits SHALL be inverted after synchronization when KEY_ACTIVE_LOW=1, and passed unchanged when it is 0, so the key field always reads 1 = pressed.
REQ-011 Each bit SHALL have an independent stable register and a saturating counter of width ceil(log2(DEBOUNCE_CYCLES))+1.
REQ-012 While the synchronized bit equals its stable value, its counter SHALL be cleared to 0 on every edge.
REQ-013 While the synchronized bit differs from its stable value, its counter SHALL increment by 1 on every edge.
REQ-014 On the edge where the bit differs and the counter equals DEBOUNCE_CYCLES-1, the stable register SHALL load the synchronized value and the counter SHALL clear to 0.
REQ-015 A mismatch lasting fewer than DEBOUNCE_CYCLES consecutive cycles SHALL leave the stable value unchanged, and the counter SHALL restart from 0 on the next mismatch.
REQ-016 Latency SHALL be exactly DEBOUNCE_CYCLES+2 rising edges, counted from the edge that first samples a clean new raw level up to and including the edge that updates io_input_bus.
REQ-017 io_input_bus SHALL be the stable registers only, with no combinational path from raw_key or raw_sw.
REQ-018 input_changed SHALL be registered and high for exactly the one cycle after any stable bit updates; simultaneous updates of several bits SHALL give a single pulse.
REQ-019 Bits SHALL not interact: activity on one bit SHALL NOT affect another bit's counter or timing.
REQ-020 With DEBOUNCE_CYCLES=1, a bit SHALL update on the first mismatch edge, giving a latency of 3 edges.

Reset
REQ-021 While reset=0, every flop SHALL be forced asynchronously to its inactive level: synchronizers hold the released/low level, counters 0, stable registers 0, io_input_bus = 14'h0000, input_changed = 0.
REQ-022 Deassertion of reset SHALL take effect on the next rising clock edge, and a raw level that is already active SHALL then take DEBOUNCE_CYCLES+2 edges to appear.
REQ-023 Reset asserted mid-count SHALL discard all partial counts, and no input_changed pulse SHALL be generated by reset itself.

Verification (DEBOUNCE_CYCLES=4, KEY_ACTIVE_LOW=1)
REQ-024 Reset with raw_key=4'hF, raw_sw=0 -> io_input_bus=14'h0000 and input_changed=0 during reset and for all cycles after release.
REQ-025 raw_sw[3] rising before edge 0 and held high -> io_input_bus=14'h0008 after edge 5, with input_changed=1 only in the cycle after edge 5.
REQ-026 raw_key[0] low for 3 cycles then high (glitch) -> io_input_bus stays 14'h0000 and input_changed never pulses.
REQ-027 raw_key=4'h6 and raw_sw=10'h201 applied on the same edge and held -> io_input_bus=14'h2601 on the same edge with a single one-cycle input_changed pulse.
REQ-028 raw_sw[0] held high 3 cycles, low 1 cycle, then high again -> the update occurs 6 edges after the final rise, not earlier.
REQ-029 reset driven low for one cycle mid-count while raw_sw[9] is high -> io_input_bus reads 0 immediately, and bit 9 reappears DEBOUNCE_CYCLES+2 edges after release.
